dlx_mem_interface: RTL and testbench

- Memory-port stage that sits directly downstream of the multicycle DLX control unit and consumes its memory-access signals: MemRead, MemWrite, IorD, IRWrite.
- Muxes the address (PC or ALUOut) and drives a req/ack external memory bus.
- Captures read data into the Instruction Register (IR) or the Memory Data Register (MDR).
- Returns Stall to the control unit so it holds its state while an access is in flight. Flags misaligned, conflicting and timed-out accesses.

---
 rtl/dlx_pkg.sv | 48 ++++
 rtl/dlx_mem_timeout.sv | 35 +++
 rtl/dlx_mem_interface.sv | 164 ++++++++++++++++
 tb/tb_dlx_mem_interface.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// dlx_pkg: definitions shared by the DLX memory-port stage and the
// multicycle control unit.
//   - mem_state_t : memory-port FSM state encoding
//   - OPC_*/FUNC_* : instruction field positions
//   - OP_*/FN_*    : DLX opcode and R-type function codes
//   - is_misaligned: word-alignment test on the two address LSBs
package dlx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } mem_state_t;

    // Instruction field positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;

    // DLX opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // A word access must have its two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dlx_mem_timeout.sv
// dlx_mem_timeout: wait-state counter for a memory access in flight.
// Ports:
//   clk     in  clock, rising edge
//   reset_n in  synchronous active-low reset
//   clr     in  force the count to zero
//   en      in  count one more cycle without completion
//   expire  out high when this enabled cycle brings the count to TIMEOUT
module dlx_mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] count_reg;

    // Flag on the cycle whose increment would reach TIMEOUT, so the
    // caller can leave on the same edge the count gets there.
    assign expire = en && (count_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dlx_mem_interface.sv
// dlx_mem_interface: memory-port stage behind the multicycle DLX control.
// Muxes PC/ALUOut onto a req/ack memory bus, captures read data into IR or
// MDR, stalls the control unit while an access is in flight and raises a
// sticky BusError on misaligned, conflicting or timed-out accesses.
// Ports:
//   Clock, Reset_n               clock / synchronous active-low reset
//   MemRead, MemWrite, IorD,
//   IRWrite                      control-unit access signals
//   PC, ALUOut, WriteData        address sources and store data
//   Instr, Opcode, Func, MDR     captured instruction / data
//   Stall, BusError              status back to the control unit
//   mem_addr, mem_wdata,
//   mem_req, mem_we              external bus request
//   mem_ack, mem_rdata           external bus completion
module dlx_mem_interface
    import dlx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        Func,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              BusError,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    mem_state_t        state_reg;
    logic [DATA_W-1:0] instr_reg;
    logic [DATA_W-1:0] mdr_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic              bus_error_reg;
    logic              to_ir_reg;

    logic              req;
    logic              conflict;
    logic              bad_align;
    logic [ADDR_W-1:0] sel_addr;
    logic              to_clr;
    logic              to_en;
    logic              to_expire;

    assign req       = MemRead | MemWrite;
    assign conflict  = MemRead & MemWrite;
    assign sel_addr  = IorD ? ALUOut : PC;
    assign bad_align = (ALIGN_CHECK != 0) && is_misaligned(sel_addr[1:0]);

    // Counter is held at zero while idle, so every access starts from 0.
    assign to_clr = (state_reg == IDLE);
    assign to_en  = (state_reg == BUSY) && !mem_ack;

    dlx_mem_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (Clock),
        .reset_n (Reset_n),
        .clr     (to_clr),
        .en      (to_en),
        .expire  (to_expire)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            instr_reg     <= '0;
            mdr_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            bus_error_reg <= 1'b0;
            to_ir_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= WriteData;
                        mem_we_reg    <= MemWrite;
                        to_ir_reg     <= IRWrite;
                        // A bad access never reaches the bus.
                        if (conflict || bad_align) begin
                            state_reg     <= ERROR;
                            bus_error_reg <= 1'b1;
                        end else begin
                            state_reg   <= BUSY;
                            mem_req_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Completion wins over a timeout on the same cycle.
                    if (mem_ack) begin
                        if (!mem_we_reg) begin
                            if (to_ir_reg) begin
                                instr_reg <= mem_rdata;
                            end else begin
                                mdr_reg <= mem_rdata;
                            end
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else if (to_expire) begin
                        mem_req_reg   <= 1'b0;
                        bus_error_reg <= 1'b1;
                        state_reg     <= ERROR;
                    end
                end
                // The control's request is still asserted here; do not
                // re-sample it or the same access would repeat.
                DONE:    state_reg <= IDLE;
                ERROR:   state_reg <= ERROR;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the control holds in the very
    // cycle it raises a request.
    always_comb begin
        Stall = 1'b0;
        case (state_reg)
            IDLE:    Stall = req;
            BUSY:    Stall = 1'b1;
            DONE:    Stall = 1'b0;
            ERROR:   Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    assign Instr     = instr_reg;
    assign Opcode    = instr_reg[OPC_HI:OPC_LO];
    assign Func      = instr_reg[FUNC_HI:FUNC_LO];
    assign MDR       = mdr_reg;
    assign BusError  = bus_error_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;

endmodule

// File: tb/tb_dlx_mem_interface.sv
// tb_dlx_mem_interface: randomized self-checking bench for dlx_mem_interface.
// A transaction-level model predicts each access outcome (completion,
// immediate error or timeout) and the IR/MDR contents.
module tb_dlx_mem_interface;

    localparam int TB_TIMEOUT = 6;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] PC, ALUOut, WriteData;
    logic [31:0] Instr, MDR;
    logic [5:0]  Opcode, Func;
    logic        Stall, BusError;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] exp_instr;
    logic [31:0] exp_mdr;

    always #5 Clock = ~Clock;

    dlx_mem_interface #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .TIMEOUT     (TB_TIMEOUT),
        .TO_W        (8),
        .ALIGN_CHECK (1)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PC        (PC),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .Instr     (Instr),
        .Opcode    (Opcode),
        .Func      (Func),
        .MDR       (MDR),
        .Stall     (Stall),
        .BusError  (BusError),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_controls();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_instr"}, Instr, exp_instr);
        check_eq({tag, "_mdr"}, MDR, exp_mdr);
    endtask

    // One-edge reset from the post-edge point; model registers clear.
    task automatic do_reset();
        clear_controls();
        mem_ack = 1'b0;
        Reset_n = 1'b0;
        @(posedge Clock); #1;
        Reset_n   = 1'b1;
        exp_instr = '0;
        exp_mdr   = '0;
        @(negedge Clock);
        check_eq("rst_buserr", 32'(BusError), 32'd0);
        check_eq("rst_stall", 32'(Stall), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_regs("rst");
        @(posedge Clock); #1;
    endtask

    // Idle cycles with stray acks, which must be ignored.
    task automatic idle_gap(input int n);
        clear_controls();
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            @(negedge Clock);
            check_eq("idle_stall", 32'(Stall), 32'd0);
            check_eq("idle_req", 32'(mem_req), 32'd0);
            @(posedge Clock); #1;
        end
        mem_ack = 1'b0;
        @(negedge Clock);
        check_regs("idle");
        @(posedge Clock); #1;
    endtask

    // One control-unit access. ack_at = BUSY cycle (1-based) carrying
    // mem_ack, 0 = never. rst_mid resets during the 2nd BUSY cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic iord, input logic irw,
                           input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata, input bit rst_mid);
        logic [31:0] addr;
        bit          imm_err;
        bit          fin;
        int          stall_cnt;
        int          k;
        addr      = iord ? alu : pc;
        imm_err   = (rd && wr) || (addr[1:0] != 2'b00);
        fin       = 1'b0;
        stall_cnt = 0;
        k         = 0;
        $display("txn rd=%0d wr=%0d iord=%0d irw=%0d addr=%h wd=%h ack_at=%0d rdata=%h rst_mid=%0d",
                 rd, wr, iord, irw, addr, wd, ack_at, rdata, rst_mid);
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        PC = pc; ALUOut = alu; WriteData = wd;
        @(negedge Clock);
        check_eq("req_stall", 32'(Stall), 32'd1);
        check_eq("req_noreq", 32'(mem_req), 32'd0);
        stall_cnt++;
        @(posedge Clock); #1;
        if (imm_err) begin
            for (int i = 0; i < 3; i++) begin
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge Clock);
                check_eq("err_buserr", 32'(BusError), 32'd1);
                check_eq("err_noreq", 32'(mem_req), 32'd0);
                check_eq("err_stall", 32'(Stall), 32'd1);
                @(posedge Clock); #1;
            end
            check_regs("err");
            do_reset();
            fin = 1'b1;
        end
        while (!fin) begin
            k++;
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : $urandom();
            @(negedge Clock);
            stall_cnt++;
            check_eq("busy_req", 32'(mem_req), 32'd1);
            check_eq("busy_stall", 32'(Stall), 32'd1);
            check_eq("busy_addr", mem_addr, addr);
            check_eq("busy_we", 32'(mem_we), 32'(wr));
            if (wr) check_eq("busy_wdata", mem_wdata, wd);
            if (rst_mid && k == 2) begin
                mem_ack = 1'b0;
                Reset_n = 1'b0;
                @(posedge Clock); #1;
                Reset_n = 1'b1;
                clear_controls();
                exp_instr = '0;
                exp_mdr   = '0;
                @(negedge Clock);
                check_eq("rstmid_req", 32'(mem_req), 32'd0);
                check_eq("rstmid_stall", 32'(Stall), 32'd0);
                check_regs("rstmid");
                // Late ack from the abandoned access
                @(posedge Clock); #1;
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                @(posedge Clock); #1;
                mem_ack = 1'b0;
                @(negedge Clock);
                check_eq("late_req", 32'(mem_req), 32'd0);
                check_regs("late");
                @(posedge Clock); #1;
                fin = 1'b1;
            end else begin
                @(posedge Clock); #1;
                mem_ack = 1'b0;
                if (k == ack_at) begin
                    if (rd) begin
                        if (irw) exp_instr = rdata;
                        else     exp_mdr   = rdata;
                    end
                    @(negedge Clock);
                    check_eq("done_stall", 32'(Stall), 32'd0);
                    check_eq("done_req", 32'(mem_req), 32'd0);
                    check_eq("stall_span", 32'(stall_cnt), 32'(ack_at + 1));
                    check_regs("done");
                    check_eq("done_opcode", 32'(Opcode), 32'(exp_instr[31:26]));
                    check_eq("done_func", 32'(Func), 32'(exp_instr[5:0]));
                    @(posedge Clock); #1;
                    clear_controls();
                    fin = 1'b1;
                end else if (k == TB_TIMEOUT) begin
                    for (int i = 0; i < 2; i++) begin
                        mem_ack   = 1'b1;
                        mem_rdata = $urandom();
                        @(negedge Clock);
                        check_eq("to_buserr", 32'(BusError), 32'd1);
                        check_eq("to_noreq", 32'(mem_req), 32'd0);
                        check_eq("to_stall", 32'(Stall), 32'd1);
                        @(posedge Clock); #1;
                    end
                    mem_ack = 1'b0;
                    check_regs("to");
                    do_reset();
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r_pc, r_alu, r_wd, r_data;
        logic        r_rd, r_wr, r_iord, r_irw;
        int          r_ack, sel;
        bit          r_rst;

        clear_controls();
        PC = '0; ALUOut = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        exp_instr = '0; exp_mdr = '0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        @(negedge Clock);
        check_eq("reset_instr", Instr, 32'd0);
        check_eq("reset_mdr", MDR, 32'd0);
        check_eq("reset_req", 32'(mem_req), 32'd0);
        check_eq("reset_we", 32'(mem_we), 32'd0);
        check_eq("reset_addr", mem_addr, 32'd0);
        check_eq("reset_wdata", mem_wdata, 32'd0);
        check_eq("reset_buserr", 32'(BusError), 32'd0);
        check_eq("reset_stall", 32'(Stall), 32'd0);
        @(posedge Clock); #1;

        // Directed scenarios
        run_txn(1, 0, 0, 1, 32'h100, 32'h0, 32'h0, 1, 32'h5022000A, 0);
        check_eq("fetch_opcode", 32'(Opcode), 32'h14);
        run_txn(1, 0, 1, 0, 32'h104, 32'h2004, 32'h0, 5, 32'hDEADBEEF, 0);
        check_eq("load_instr_kept", Instr, 32'h5022000A);
        run_txn(0, 1, 1, 0, 32'h108, 32'h3000, 32'h12345678, 3, 32'hCAFEF00D, 0);
        check_eq("store_mdr_kept", MDR, 32'hDEADBEEF);
        idle_gap(3);
        run_txn(1, 0, 1, 0, 32'h10C, 32'h2008, 32'h0, 0, 32'h0, 0);
        run_txn(1, 0, 1, 0, 32'h110, 32'h2002, 32'h0, 1, 32'h11111111, 0);
        run_txn(1, 1, 1, 0, 32'h114, 32'h2010, 32'h0, 1, 32'h22222222, 0);
        run_txn(1, 0, 0, 1, 32'h118, 32'h0, 32'h0, 4, 32'h33333333, 1);
        run_txn(1, 0, 0, 1, 32'h11C, 32'h0, 32'h0, TB_TIMEOUT, 32'h44444444, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            sel    = $urandom_range(0, 9);
            r_pc   = $urandom() & 32'hFFFF_FFFC;
            r_alu  = $urandom() & 32'hFFFF_FFFC;
            r_wd   = $urandom();
            r_data = $urandom();
            r_iord = 1'($urandom_range(0, 1));
            r_irw  = 1'($urandom_range(0, 1));
            r_rd   = 1'b1;
            r_wr   = 1'b0;
            r_ack  = $urandom_range(1, TB_TIMEOUT);
            r_rst  = 1'b0;
            case (sel)
                0, 1, 2: ;
                3, 4:    begin r_rd = 1'b0; r_wr = 1'b1; end
                5:       r_ack = ($urandom_range(0, 1) != 0) ? 0 : TB_TIMEOUT + 1;
                6:       begin
                             if (r_iord) r_alu = r_alu | 32'($urandom_range(1, 3));
                             else        r_pc  = r_pc  | 32'($urandom_range(1, 3));
                         end
                7:       r_wr = 1'b1;
                8:       begin r_rst = 1'b1; r_ack = $urandom_range(3, TB_TIMEOUT); end
                default: r_irw = 1'b1;
            endcase
            run_txn(r_rd, r_wr, r_iord, r_irw, r_pc, r_alu, r_wd, r_ack, r_data, r_rst);
            idle_gap($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
